fifo_push_arb: RTL and testbench

Round-robin push arbiter that shares one `fifo` write port among NREQ packet producers. Each requester presents a valid/ready/last stream. The arbiter grants one requester at a time for a whole packet and drives `push`/`data_in` of the downstream FIFO. It throttles on the FIFO's `alFull`, so no beat is ever dropped by the FIFO's internal full guard.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_push_arb_rr_pick.sv | 29 ++
 rtl/fifo_push_arb.sv | 111 +++++++++++
 tb/tb_fifo_push_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helper for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // ceil(log2(n)), never below 1 so a 1-entry range still gets a real bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_push_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic [2*NREQ-1:0] dbl_req;
  logic [2*NREQ-1:0] dbl_gnt;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_gnt;

  // ptr is always < NREQ, so the doubled vector handles non-power-of-2 wrap
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[NREQ-1:0];
    rot_gnt = rot_req & (~rot_req + 1'b1);
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    gnt     = dbl_gnt[2*NREQ-1:NREQ];
    any     = |req;
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port, throttled by alFull.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 24,
  parameter int MAX_BEATS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 fifo_push,
  output logic [DW-1:0]        fifo_data,
  input  logic                 fifo_alFull,
  input  logic                 fifo_full,
  output logic [NREQ-1:0]      grant,
  output logic                 err_len
);

  localparam int PW = clog2_min1(NREQ);
  localparam int BW = clog2_min1(MAX_BEATS);
  localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BEATS - 1);
  localparam logic [PW-1:0] PTR_TOP = PW'(NREQ - 1);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt, g_idx, g_idx_inc;
  logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            path_ok, accept, last_g, force_rel;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) g_idx = g_idx | PW'(i);
    g_idx_inc = (g_idx == PTR_TOP) ? '0 : g_idx + 1'b1;
  end

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++)
      fifo_data = fifo_data | (req_data[i*DW +: DW] & {DW{grant[i]}});
  end

  // full is a safety term only; alFull headroom normally keeps it low
  assign path_ok   = !fifo_alFull && !fifo_full;
  assign req_ready = grant & {NREQ{path_ok}};
  assign accept    = (state == XFER) && |(req_valid & req_ready);
  assign last_g    = |(req_last & grant);
  assign force_rel = accept && !last_g && (beat_cnt == CNT_MAX);
  assign fifo_push = accept;
  assign err_len   = force_rel;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_any && !fifo_alFull) begin
          grant_nxt    = pick_gnt;
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (last_g || force_rel) begin
            rr_ptr_nxt = g_idx_inc;
            grant_nxt  = '0;
            state_nxt  = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb with queue-fed sources and a 2-cycle-lag FIFO model.
module tb_fifo_push_arb;
  localparam int NREQ = 4, DW = 24, MAXB = 8, DEPTH = 16, HEADROOM = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0]    req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_push, fifo_alFull, fifo_full, err_len;
  logic [DW-1:0]      fifo_data;

  fifo_push_arb #(.NREQ(NREQ), .DW(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_push(fifo_push), .fifo_data(fifo_data),
    .fifo_alFull(fifo_alFull), .fifo_full(fifo_full),
    .grant(grant), .err_len(err_len)
  );

  always #5 clk = ~clk;

  // sources: beat tables, consumed on sampled handshakes
  logic [DW:0] src_mem [NREQ][128];
  int src_n  [NREQ];
  int src_rd [NREQ];
  bit src_en [NREQ];
  bit acc_s  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign req_valid[i]          = src_en[i] && (src_rd[i] < src_n[i]);
    assign req_data[i*DW +: DW]  = src_mem[i][src_rd[i]][DW-1:0];
    assign req_last[i]           = src_mem[i][src_rd[i]][DW];
  end

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NREQ; i++)
      if (acc_s[i]) src_rd[i] <= src_rd[i] + 1;
  end

  // monitor: sampled mid-cycle, away from the active edge
  logic          push_s;
  logic [DW-1:0] data_s;
  logic [DW-1:0] plog_d[$];
  int            plog_c[$];
  int            elog[$];
  int viol_cnt = 0, full_cnt = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) acc_s[i] <= req_valid[i] & req_ready[i];
    push_s <= fifo_push;
    data_s <= fifo_data;
    if (rst_n && fifo_push === 1'b1) begin
      plog_d.push_back(fifo_data);
      plog_c.push_back(cyc - t0);
    end
    if (rst_n && err_len === 1'b1) elog.push_back(cyc - t0);
    if (rst_n && fifo_alFull && (req_ready != '0)) viol_cnt <= viol_cnt + 1;
    if (fifo_full) full_cnt <= full_cnt + 1;
  end

  // FIFO model: registered wen, then registered count compare
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rd_log[$];
  logic          wen_q;
  logic [DW-1:0] wd_q;
  int            drain_mode;
  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      wen_q       <= 1'b0;
      fifo_alFull <= 1'b0;
      fifo_full   <= 1'b0;
    end else begin
      wen_q <= push_s;
      wd_q  <= data_s;
      if (wen_q === 1'b1) fq.push_back(wd_q);
      if (fq.size() > 0 && (drain_mode == 1 || (drain_mode == 2 && (cyc % 2) == 0)))
        rd_log.push_back(fq.pop_front());
      fifo_alFull <= (fq.size() >= DEPTH - HEADROOM);
      fifo_full   <= (fq.size() >= DEPTH);
    end
  end

  int n_chk = 0, n_fail = 0;
  int pbase = 0, ebase = 0, rbase = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pd(input int k);
    return (pbase + k < plog_d.size()) ? int'(plog_d[pbase + k]) : -1;
  endfunction

  function automatic int pc(input int k);
    return (pbase + k < plog_c.size()) ? plog_c[pbase + k] : -1;
  endfunction

  task automatic add_pkt(input int r, input int n, input int base);
    for (int b = 0; b < n; b++) begin
      src_mem[r][src_n[r]] = {(b == n - 1), DW'(base + b)};
      src_n[r]++;
    end
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    t0    = cyc;
    pbase = plog_d.size();
    ebase = elog.size();
    rbase = rd_log.size();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    release_rst();
  endtask

  task automatic go_to(input int c);
    int n;
    n = 0;
    while ((cyc - t0) < c && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < lim) begin
      @(posedge clk); #1;
      n++;
      done = (grant == '0);
      for (int i = 0; i < NREQ; i++) if (src_rd[i] != src_n[i]) done = 1'b0;
    end
    chk(tag, 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int exp_d, exp_c, v0, f0;
    bit seen;
    static int at_c[7]  = '{1, 2, 3, 4, 5, 7, 8};
    static int ov_c[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 13};

    rst_n = 1'b0;
    drain_mode = 1;
    for (int i = 0; i < NREQ; i++) src_en[i] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_push", 32'(fifo_push), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_err", 32'(err_len), 0);

    // fairness: 1-beat packets from everyone, grants rotate 0,1,2,3 every 2 cycles
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NREQ; r++) add_pkt(r, 1, (r << 16) + p);
    wait_idle("fair_done", 100);
    chk("fair_npush", plog_d.size() - pbase, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fair_d%0d", k), pd(k), ((k % 4) << 16) + k / 4);
      chk($sformatf("fair_c%0d", k), pc(k), 2 * k + 1);
    end

    // atomicity: req0 5-beat packet, req1 waiting throughout
    do_reset();
    add_pkt(0, 5, 'h000100);
    add_pkt(1, 2, 'h010200);
    wait_idle("atom_done", 100);
    chk("atom_npush", plog_d.size() - pbase, 7);
    for (int k = 0; k < 7; k++) begin
      exp_d = (k < 5) ? 'h000100 + k : 'h010200 + k - 5;
      chk($sformatf("atom_d%0d", k), pd(k), exp_d);
      chk($sformatf("atom_c%0d", k), pc(k), at_c[k]);
    end

    // overlong: req2 forced off after 8 beats, req3 slips in, req2 resumes
    do_reset();
    add_pkt(2, 10, 'h020300);
    add_pkt(3, 1, 'h030400);
    wait_idle("ovl_done", 100);
    chk("ovl_npush", plog_d.size() - pbase, 11);
    chk("ovl_nerr", elog.size() - ebase, 1);
    chk("ovl_errc", (elog.size() > ebase) ? elog[ebase] : -1, 8);
    for (int k = 0; k < 11; k++) begin
      exp_d = (k < 8) ? 'h020300 + k : (k == 8) ? 'h030400 : 'h020300 + k - 1;
      chk($sformatf("ovl_d%0d", k), pd(k), exp_d);
      chk($sformatf("ovl_c%0d", k), pc(k), ov_c[k]);
    end

    // mid-packet stall: owner drops valid for 3 cycles
    do_reset();
    add_pkt(1, 4, 'h010500);
    add_pkt(2, 1, 'h020600);
    go_to(3);
    src_en[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stl_grant%0d", c), 32'(grant), 32'h2);
      chk($sformatf("stl_push%0d", c), 32'(fifo_push), 0);
      chk($sformatf("stl_oth%0d", c), 32'(req_ready & 4'b1101), 0);
    end
    go_to(6);
    src_en[1] = 1'b1;
    wait_idle("stl_done", 100);
    for (int k = 2; k < 5; k++) begin
      exp_d = (k < 4) ? 'h010500 + k : 'h020600;
      exp_c = (k < 4) ? k + 4 : 9;
      chk($sformatf("stl_d%0d", k), pd(k), exp_d);
      chk($sformatf("stl_c%0d", k), pc(k), exp_c);
    end

    // backpressure: no draining until alFull, then half-rate drain
    do_reset();
    drain_mode = 0;
    v0 = viol_cnt;
    f0 = full_cnt;
    add_pkt(0, 8, 'h000700);
    add_pkt(0, 8, 'h000708);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (fifo_alFull) seen = 1'b1;
    end
    chk("bp_alfull_rise", 32'(seen), 1);
    drain_mode = 2;
    for (int n = 0; n < 400 && (rd_log.size() - rbase) < 16; n++) @(negedge clk);
    chk("bp_nread", rd_log.size() - rbase, 16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("bp_rd%0d", k), (rbase + k < rd_log.size()) ? int'(rd_log[rbase + k]) : -1,
          'h000700 + k);
    chk("bp_ready_gate", viol_cnt - v0, 0);
    chk("bp_full", full_cnt - f0, 0);
    chk("bp_nerr", elog.size() - ebase, 0);
    drain_mode = 1;
    wait_idle("bp_done", 50);

    // reset during req1 beat 3, then restart from rr_ptr 0
    do_reset();
    add_pkt(0, 1, 'h000800);
    add_pkt(1, 5, 'h010900);
    go_to(5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_beat3", 32'(fifo_data), 'h010902);
    go_to(6);
    @(negedge clk);
    chk("rm_grant", 32'(grant), 0);
    chk("rm_push", 32'(fifo_push), 0);
    add_pkt(0, 1, 'h000a00);
    add_pkt(3, 1, 'h030b00);
    go_to(7);
    release_rst();
    wait_idle("rm_done", 100);
    chk("rm_d0", pd(0), 'h000a00);
    chk("rm_c0", pc(0), 1);
    chk("rm_d1", pd(1), 'h010903);
    chk("rm_c1", pc(1), 3);
    chk("rm_d3", pd(3), 'h030b00);
    chk("rm_c3", pc(3), 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
